// File: rtl/uart_tx_frame_if.sv
// Parallel-side request bus and serial-side outputs of the UART frame transmitter.
// data_valid is a request and busy is the inverted ready: a word transfers on a rising edge where data_valid=1 and busy=0.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;
  logic [2:0]            state_dbg;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy, state_dbg
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy, state_dbg
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// One bit per clk edge; tx_out and busy are driven straight from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.data_valid) state_d = START;
      START:   state_d = DATA;
      DATA:    if (cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each register holds the value of the bit being shown during the next state.
  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.data_valid) begin
          shreg_d   = bus.p_data;
          par_en_d  = bus.par_en;
          par_bit_d = (^bus.p_data) ^ bus.par_typ;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        tx_d    = shreg_q[0];
        shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          tx_d = par_en_q ? par_bit_q : 1'b1;
        end else begin
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
          cnt_d   = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        tx_d = 1'b1;
      end
      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.tx_out    = tx_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial transmitter of the UART link, the transmit-side counterpart of the receive path (sampler, start/parity/stop checkers).
- Accepts one parallel byte with a valid strobe and serialises it LSB-first as a start bit, DATA_WIDTH data bits, an optional parity bit and one stop bit.
- Runs on the TX baud clock: one serial bit per clk cycle.
- Sits between the system/ALU result path and the UART TX pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame. Legal values are 5 to 9.

Ports:
- clk  input  1  TX baud clock. One bit is transmitted per rising edge.
- rst  input  1  asynchronous, active-high reset.
- p_data  input  DATA_WIDTH  parallel data word. Sampled only on the accept edge.
- data_valid  input  1  request to send p_data.
- par_en  input  1  1 inserts a parity bit. Sampled on the accept edge.
- par_typ  input  1  0 selects even parity, 1 selects odd. Sampled on the accept edge.
- tx_out  output  1  serial line. Registered. Idle level is 1.
- busy  output  1  registered. High while a frame is on the line.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state goes to IDLE, tx_out=1, busy=0.
  - Bit counter, data shift register and parity latches are cleared.
  - A partial frame is abandoned and is not resumed after reset releases.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept:
  - The accept condition is data_valid=1 while state=IDLE, evaluated at the rising edge.
  - On the accept edge, latch p_data, par_en and par_typ, and compute parity_bit = ^p_data XOR par_typ.
  - On the same edge, set tx_out<=0 and busy<=1, and go to START. The start bit therefore appears the cycle after the accept edge, i.e. 1-cycle latency.
- data_valid while busy=1 is ignored. No queuing and no change to the frame in flight.
- START, 1 cycle: on exit, drive tx_out<=data[0] and go to DATA with bit counter=0.
- DATA, DATA_WIDTH cycles:
  - Each edge shifts out the next bit (LSB first) and increments the counter.
  - After bit DATA_WIDTH-1, go to PARITY with tx_out<=parity_bit if the latched par_en=1.
  - Otherwise go to STOP with tx_out<=1.
- PARITY, 1 cycle: go to STOP with tx_out<=1.
- STOP, 1 cycle: go to IDLE with tx_out<=1 and busy<=0.
- busy timing:
  - busy is high for exactly 1+DATA_WIDTH+par_en+1 cycles.
  - With the default width that is 10 cycles without parity and 11 with parity.
- Inter-frame gap: the minimum is one IDLE cycle. An accept can occur on the edge at which busy falls to 0 in IDLE, i.e. the first IDLE cycle, so back-to-back frames are separated by at least one idle-high bit time beyond the stop bit.
- Input stability:
  - p_data, par_en and par_typ may change freely after the accept edge.
  - Changes mid-frame must not affect tx_out.
- Glitch-free output: tx_out comes straight from a flop, with no combinational path from inputs to tx_out or busy.
- Counter width is $clog2(DATA_WIDTH). The counter never wraps inside a frame and is reset to 0 on entry to DATA.

Test Plan:
- Reset, then idle for 5 cycles → tx_out=1 and busy=0 throughout.
- p_data=0xA5, par_en=0, 1-cycle data_valid → starting the cycle after accept, tx_out sequence is 0,1,0,1,0,0,1,0,1,1 (10 cycles), and busy is high for exactly those 10 cycles.
- p_data=0xA5 with par_en=1, first with par_typ=0 and then with par_typ=1:
  - tx_out sequence is 0,1,0,1,0,0,1,0,1,P,1 (11 cycles).
  - P=0 for even parity and P=1 for odd parity.
  - p_data=0x00 with odd parity gives P=1.
- Frame 0x3C followed by data_valid=1 and p_data=0xFF held high for the whole frame:
  - Mid-frame data_valid has no effect.
  - The second frame starts after exactly one idle cycle and carries 0xFF (eight 1s after the start bit).
  - The first frame is intact: 0,0,0,1,1,1,1,0,0,1.
- Assert rst asynchronously (between clock edges) during DATA bit 4 of 0x55:
  - tx_out=1 and busy=0 immediately, without waiting for a clock edge.
  - After release, a new 0x81 frame transmits correctly: 0,1,0,0,0,0,0,0,1,1.
